// File: rtl/concat_pkg.sv
// concat_pkg: shared definitions for the concat_packer block.
//   MODE_CONCAT / MODE_REPLICATE : encodings of the mode input.
//   state_e                      : packer FSM states (FILL builds a word,
//                                  HOLD presents a finished word).
package concat_pkg;

   localparam logic MODE_CONCAT    = 1'b0;
   localparam logic MODE_REPLICATE = 1'b1;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/concat_packer_if.sv
// concat_packer_if: beat-in / word-out stream bundle for concat_packer.
//   mode, in_data, in_valid, in_ready, [in_last]  : narrow input side
//   out_data, out_valid, out_ready, [out_count]   : wide output side
//   master modport : producer/consumer environment
//   slave modport  : the packer itself
// Optional macro CONCAT_PACKER_LAST_EN adds in_last and out_count.
interface concat_packer_if #(
   parameter int WIDTH = 4,
   parameter int COUNT = 2
);
   localparam int CNT_W = $clog2(COUNT + 1);

   logic                     mode;
   logic [WIDTH-1:0]         in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH*COUNT-1:0]   out_data;
   logic                     out_valid;
   logic                     out_ready;
`ifdef CONCAT_PACKER_LAST_EN
   logic                     in_last;
   logic [CNT_W-1:0]         out_count;

   modport master (
      output mode, in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_count
   );
   modport slave (
      input  mode, in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_count
   );
`else
   modport master (
      output mode, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );
   modport slave (
      input  mode, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
`endif

endinterface

// File: rtl/concat_out_stage.sv
// concat_out_stage: one-word output register with valid/ready hold.
//   clk, rst       : clock, synchronous active-high reset
//   load_i         : capture load_data_i (and load_count_i) and raise valid
//   load_data_i    : finished word
//   load_count_i   : populated slots (only with CONCAT_PACKER_LAST_EN)
//   ready_i        : downstream consumes the word when valid_o && ready_i
//   valid_o/data_o/count_o : registered word presented downstream
// A load in the same cycle as consumption wins, so back-to-back words
// stream at one per cycle. data_o keeps its value after consumption.
module concat_out_stage #(
   parameter int DW = 8
`ifdef CONCAT_PACKER_LAST_EN
   ,
   parameter int CNT_W = 2
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [DW-1:0]    load_data_i,
`ifdef CONCAT_PACKER_LAST_EN
   input  logic [CNT_W-1:0] load_count_i,
   output logic [CNT_W-1:0] count_o,
`endif
   input  logic             ready_i,
   output logic             valid_o,
   output logic [DW-1:0]    data_o
);

   logic          valid_q;
   logic [DW-1:0] data_q;
`ifdef CONCAT_PACKER_LAST_EN
   logic [CNT_W-1:0] count_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
`ifdef CONCAT_PACKER_LAST_EN
         count_q <= '0;
`endif
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= load_data_i;
`ifdef CONCAT_PACKER_LAST_EN
         count_q <= load_count_i;
`endif
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
`ifdef CONCAT_PACKER_LAST_EN
   assign count_o = count_q;
`endif

endmodule

// File: rtl/concat_packer.sv
// concat_packer: packs WIDTH-bit beats into WIDTH*COUNT-bit words, either
// by concatenating COUNT beats (first beat in the MSBs) or by replicating
// one beat COUNT times.
//   clk, rst : clock, synchronous active-high reset
//   bus      : concat_packer_if.slave (mode, in_*, out_*)
// Optional macro CONCAT_PACKER_LAST_EN: in_last closes a concatenated word
// early (left-justified, zero-filled LSBs) and out_count reports the
// number of populated slots.
module concat_packer
   import concat_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int COUNT = 2
) (
   input  logic             clk,
   input  logic             rst,
   concat_packer_if.slave   bus
);

   localparam int DW = WIDTH * COUNT;
   localparam int SW = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(COUNT - 1);
`ifdef CONCAT_PACKER_LAST_EN
   localparam int CNT_W = $clog2(COUNT + 1);
   logic [CNT_W-1:0] load_count;
`endif

   state_e         state_q, state_d;
   logic [SW-1:0]  slot_q, slot_d;
   logic           mode_q, mode_d;
   logic [DW-1:0]  acc_q, acc_d;

   logic           accept;
   logic           eff_mode;
   logic           early;
   logic           load;
   logic [DW-1:0]  shifted;
   logic [DW-1:0]  load_word;

   always_comb begin
      bus.in_ready = (state_q == ST_FILL) ? 1'b1 : bus.out_ready;
      accept       = bus.in_valid && bus.in_ready;
      // Mode is taken live on the first beat, latched for the rest.
      eff_mode     = (slot_q == '0) ? bus.mode : mode_q;
      shifted      = (acc_q << WIDTH) | DW'(bus.in_data);
`ifdef CONCAT_PACKER_LAST_EN
      early        = bus.in_last;
`else
      early        = 1'b0;
`endif
      load         = accept && ((eff_mode == MODE_REPLICATE) ||
                                (slot_q == SLOT_LAST) || early);

      // Left-justify: beats received so far move up to the MSBs; stale
      // accumulator bits above them fall off the top. For a full word the
      // shift is zero.
      if (eff_mode == MODE_REPLICATE)
         load_word = {COUNT{bus.in_data}};
      else
         load_word = shifted << (WIDTH * (COUNT - 1 - int'(slot_q)));

`ifdef CONCAT_PACKER_LAST_EN
      if (eff_mode == MODE_REPLICATE)
         load_count = CNT_W'(COUNT);
      else
         load_count = CNT_W'(slot_q) + CNT_W'(1);
`endif

      state_d = state_q;
      slot_d  = slot_q;
      mode_d  = mode_q;
      acc_d   = acc_q;

      if (accept && (slot_q == '0))
         mode_d = bus.mode;

      if (load) begin
         state_d = ST_HOLD;
         slot_d  = '0;
      end else begin
         if ((state_q == ST_HOLD) && bus.out_ready)
            state_d = ST_FILL;
         if (accept) begin
            acc_d  = shifted;
            slot_d = slot_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FILL;
         slot_q  <= '0;
         mode_q  <= MODE_CONCAT;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         mode_q  <= mode_d;
      end
   end

   // Accumulator contents are qualified by slot_q, so it needs no reset.
   always_ff @(posedge clk) begin
      acc_q <= acc_d;
   end

   concat_out_stage #(
      .DW    (DW)
`ifdef CONCAT_PACKER_LAST_EN
      ,
      .CNT_W (CNT_W)
`endif
   ) u_out (
      .clk          (clk),
      .rst          (rst),
      .load_i       (load),
      .load_data_i  (load_word),
`ifdef CONCAT_PACKER_LAST_EN
      .load_count_i (load_count),
      .count_o      (bus.out_count),
`endif
      .ready_i      (bus.out_ready),
      .valid_o      (bus.out_valid),
      .data_o       (bus.out_data)
   );

endmodule

// File: tb/tb_concat_packer.sv
module tb_concat_packer;

   localparam int W  = 4;
   localparam int C  = 2;
   localparam int DW = W * C;
   localparam int CW = $clog2(C + 1);
`ifdef CONCAT_PACKER_LAST_EN
   localparam bit L_EN = 1'b1;
`else
   localparam bit L_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   concat_packer_if #(.WIDTH(W), .COUNT(C)) bus ();

   concat_packer #(.WIDTH(W), .COUNT(C)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: expected presented words and the partial word.
   logic [DW-1:0] wq[$];
   logic [CW-1:0] cq[$];
   logic [W-1:0]  part_q[$];
   logic          part_mode;

   logic          obs_rdy, obs_vld, exp_rdy, exp_vld;
   logic [DW-1:0] obs_data, exp_data;
   logic [CW-1:0] obs_cnt, exp_cnt;

   function automatic logic [DW-1:0] pack_beats();
      logic [DW-1:0] w = '0;
      for (int i = 0; i < part_q.size(); i++)
         w = w | (DW'(part_q[i]) << (W * (C - 1 - i)));
      return w;
   endfunction

   task automatic model_accept(input logic [W-1:0] d, input logic m, input logic l);
      logic [DW-1:0] w;
      if (part_q.size() == 0) part_mode = m;
      if (part_mode) begin
         w = '0;
         for (int i = 0; i < C; i++) w = (w << W) | DW'(d);
         wq.push_back(w);
         cq.push_back(CW'(C));
      end else begin
         part_q.push_back(d);
         if (part_q.size() == C || (L_EN && l)) begin
            wq.push_back(pack_beats());
            cq.push_back(CW'(part_q.size()));
            part_q.delete();
         end
      end
   endtask

   // One clock: drive at negedge, sample after settling, advance model.
   task automatic step(input logic v, input logic [W-1:0] d, input logic m,
                       input logic l, input logic r);
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.mode      = m;
      bus.out_ready = r;
`ifdef CONCAT_PACKER_LAST_EN
      bus.in_last   = l;
`endif
      #1;
      obs_rdy  = bus.in_ready;
      obs_vld  = bus.out_valid;
      obs_data = bus.out_data;
`ifdef CONCAT_PACKER_LAST_EN
      obs_cnt  = bus.out_count;
`else
      obs_cnt  = '0;
`endif
      exp_vld  = (wq.size() != 0);
      exp_rdy  = exp_vld ? r : 1'b1;
      exp_data = exp_vld ? wq[0] : '0;
      exp_cnt  = exp_vld ? cq[0] : '0;
      @(posedge clk);
      if (exp_vld && r) begin
         void'(wq.pop_front());
         void'(cq.pop_front());
      end
      if (v && exp_rdy) model_accept(d, m, l);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.mode = 1'b0; bus.out_ready = 1'b0;
`ifdef CONCAT_PACKER_LAST_EN
      bus.in_last = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wq.delete(); cq.delete(); part_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_tests++; if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", obs_vld); end
      n_tests++; if (obs_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 00", obs_data); end
      n_tests++; if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", obs_rdy); end
`ifdef CONCAT_PACKER_LAST_EN
      n_tests++; if (obs_cnt !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", obs_cnt); end
`endif
   endtask

   task automatic test_concat();
      do_reset();
      step(1'b1, 4'b1010, 1'b0, 1'b0, 1'b1);
      step(1'b1, 4'b0101, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL concat_early_valid got %b want 0", obs_vld); end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b1 || obs_data !== 8'b1010_0101)
         begin n_fail++; $display("FAIL concat_word got v=%b d=%b want v=1 d=10100101", obs_vld, obs_data); end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL concat_one_cycle got %b want 0", obs_vld); end
   endtask

   task automatic test_replicate();
      do_reset();
      step(1'b1, 4'b1100, 1'b1, 1'b0, 1'b1);
      step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b1 || obs_data !== 8'b1100_1100)
         begin n_fail++; $display("FAIL repl_word got v=%b d=%b want 11001100", obs_vld, obs_data); end
      step(1'b1, 4'b0001, 1'b1, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b1 || obs_data !== 8'b1111_1111)
         begin n_fail++; $display("FAIL repl_b2b_first got v=%b d=%b want 11111111", obs_vld, obs_data); end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b1 || obs_data !== 8'b0001_0001)
         begin n_fail++; $display("FAIL repl_b2b_second got v=%b d=%b want 00010001", obs_vld, obs_data); end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL repl_drop got %b want 0", obs_vld); end
   endtask

   task automatic test_hold();
      do_reset();
      step(1'b1, 4'b1100, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
         n_tests++; if (obs_vld !== 1'b1 || obs_data !== 8'b1100_0011 || obs_rdy !== 1'b0)
            begin n_fail++; $display("FAIL hold_stall[%0d] got v=%b d=%b rdy=%b want v=1 d=11000011 rdy=0", i, obs_vld, obs_data, obs_rdy); end
      end
      step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_rdy !== 1'b1 || obs_vld !== 1'b1)
         begin n_fail++; $display("FAIL hold_release got rdy=%b v=%b want 1 1", obs_rdy, obs_vld); end
      step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b0 || obs_rdy !== 1'b1)
         begin n_fail++; $display("FAIL hold_refill got v=%b rdy=%b want 0 1", obs_vld, obs_rdy); end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b1 || obs_data !== 8'b1111_0000)
         begin n_fail++; $display("FAIL hold_next_word got v=%b d=%b want 11110000", obs_vld, obs_data); end
   endtask

   task automatic test_reset_mid_word();
      do_reset();
      step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
      do_reset();
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL midreset_no_word got %b want 0", obs_vld); end
      step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
      step(1'b1, 4'b1110, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b1 || obs_data !== 8'b0001_1110)
         begin n_fail++; $display("FAIL midreset_word got v=%b d=%b want 00011110", obs_vld, obs_data); end
   endtask

   task automatic test_mode_toggle();
      do_reset();
      step(1'b1, 4'b1010, 1'b0, 1'b0, 1'b1);
      step(1'b1, 4'b0101, 1'b1, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b1 || obs_data !== 8'b1010_0101)
         begin n_fail++; $display("FAIL mode_toggle got v=%b d=%b want 10100101", obs_vld, obs_data); end
   endtask

`ifdef CONCAT_PACKER_LAST_EN
   task automatic test_last();
      do_reset();
      step(1'b1, 4'b0001, 1'b0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_vld !== 1'b1 || obs_data !== 8'b0001_0000 || obs_cnt !== 2'd1)
         begin n_fail++; $display("FAIL last_early got v=%b d=%b n=%0d want d=00010000 n=1", obs_vld, obs_data, obs_cnt); end
      step(1'b1, 4'b0110, 1'b0, 1'b0, 1'b1);
      step(1'b1, 4'b1001, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_data !== 8'b0110_1001 || obs_cnt !== 2'd2)
         begin n_fail++; $display("FAIL last_full got d=%b n=%0d want d=01101001 n=2", obs_data, obs_cnt); end
      step(1'b1, 4'b0011, 1'b1, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++; if (obs_data !== 8'b0011_0011 || obs_cnt !== 2'd2)
         begin n_fail++; $display("FAIL last_repl got d=%b n=%0d want d=00110011 n=2", obs_data, obs_cnt); end
   endtask
`endif

   task automatic test_random();
      logic v, m, l, r;
      logic [W-1:0] d;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         v = ($urandom_range(0, 3) != 0);
         m = ($urandom_range(0, 3) == 0);
         l = ($urandom_range(0, 4) == 0);
         r = ($urandom_range(0, 3) != 0);
         d = W'($urandom);
         step(v, d, m, l, r);
         n_tests++; if (obs_rdy !== exp_rdy)
            begin n_fail++; $display("FAIL rand_in_ready[%0d] got %b want %b", i, obs_rdy, exp_rdy); end
         n_tests++; if (obs_vld !== exp_vld)
            begin n_fail++; $display("FAIL rand_valid[%0d] got %b want %b", i, obs_vld, exp_vld); end
         if (exp_vld) begin
            n_tests++; if (obs_data !== exp_data)
               begin n_fail++; $display("FAIL rand_data[%0d] got %b want %b", i, obs_data, exp_data); end
            if (L_EN) begin
               n_tests++; if (obs_cnt !== exp_cnt)
                  begin n_fail++; $display("FAIL rand_count[%0d] got %0d want %0d", i, obs_cnt, exp_cnt); end
            end
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.mode = 1'b0; bus.out_ready = 1'b0;
`ifdef CONCAT_PACKER_LAST_EN
      bus.in_last = 1'b0;
`endif
      test_reset();
      test_concat();
      test_replicate();
      test_hold();
      test_reset_mid_word();
      test_mode_toggle();
`ifdef CONCAT_PACKER_LAST_EN
      test_last();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/concat_packer.md
# concat_packer

Parametrised, sequential successor to the combinational concatenation/replication operator block. Accepts a stream of WIDTH-bit beats and assembles them into COUNT*WIDTH-bit words, either by concatenating COUNT consecutive beats (first beat in MSBs) or by replicating a single beat COUNT times. Valid/ready handshakes on both sides and a one-word output register let the block sit between narrow producers and wide consumers in the datapath.

## Interface
- WIDTH, 4, bits per input beat (≥1)
- COUNT, 2, beats per output word (≥1)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = concatenate, 1 = replicate; sampled only on the first beat of a word
- in_data  input  WIDTH  input beat
- in_valid  input  1  beat offered
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_last  input  1  early word end (only with CONCAT_PACKER_LAST_EN)
- out_data  output  WIDTH*COUNT  assembled word
- out_valid  output  1  word offered
- out_ready  input  1  word consumed when out_valid && out_ready
- out_count  output  $clog2(COUNT+1)  populated slots in out_data (only with CONCAT_PACKER_LAST_EN)

## Operation
- States: FILL (building a word), HOLD (word waiting in output register).
- FILL: in_ready = 1. Each accepted beat is shifted into the accumulator at the LSB end, so after COUNT beats the first beat occupies the MSBs, equivalent to {b0, b1, …, b(COUNT-1)}. Slot counter increments from 0.
- On the beat that fills slot COUNT-1: output register loads the word, slot resets to 0, state goes to HOLD.
- Replicate mode (mode = 1 at slot 0): a single beat loads {COUNT{in_data}} into the output register and moves to HOLD. Completes in one beat.
- Mode is latched at slot 0. Changes while slot ≠ 0 are ignored until the word completes.
- HOLD: out_valid = 1 and in_ready = out_ready. If out_ready and in_valid are both high, the word is consumed and the new beat starts the next word in the same cycle. For COUNT = 1 or replicate mode, that beat reloads the output register directly and the block stays in HOLD.
- HOLD with out_ready and no input beat: out_valid drops next cycle and the block returns to FILL.
- out_data holds its value while out_valid && !out_ready. out_data is unchanged after consumption until the next load.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_count = 0, slot = 0, latched mode = 0, state FILL. in_ready = 1 in the cycle after reset deasserts.
- Reset mid-word or mid-HOLD: the partial or held word is discarded without being presented.
- Latency: out_valid rises in the cycle after the final beat is accepted.
- Throughput with out_ready held high:
  - concatenate: one word per COUNT beats;
  - replicate or COUNT = 1: one word per cycle.
- in_ready is registered-state combinational: it depends on state and out_ready, never on in_valid.

## Configuration
- CONCAT_PACKER_LAST_EN defined:
  - in_last and out_count ports exist.
  - Concatenate mode: a beat accepted with in_last closes the word early. The word is left-justified (received beats in the MSBs, remaining LSB slots zero), out_count = number of beats received, then HOLD.
  - Full words give out_count = COUNT.
  - Replicate mode: in_last is ignored and out_count = COUNT.
- CONCAT_PACKER_LAST_EN undefined: no in_last or out_count ports. Words always contain exactly COUNT beats.

## Structure
- Package concat_pkg:
  - mode constants MODE_CONCAT = 1'b0, MODE_REPLICATE = 1'b1;
  - state enum {ST_FILL, ST_HOLD}.
- One natural sub-module: concat_out_stage, the one-word output register with the valid/ready hold logic. The packer's accumulator, slot counter and FSM stay in concat_packer.

## Test plan
- WIDTH=4, COUNT=2, concatenate, beats 1010 then 0101, out_ready = 1 → out_data = 10100101, out_valid for one cycle, one cycle after second beat.
- Replicate, beat 1100 → out_data = 11001100; beats 1111, 0001 back-to-back with out_ready = 1 → words 11111111, 00010001 on consecutive cycles.
- Concatenate 1100, 0011 with out_ready = 0 for 5 cycles → out_data stable at 11000011, in_ready = 0 throughout; on out_ready = 1 the next beat 1111 is accepted in the same cycle.
- Reset asserted after first beat 1111 → no word emitted; then 0001, 1110 → 00011110.
- Mode toggled to 1 between beats 1010 and 0101 → word 10100101 (mode ignored mid-word).
- With CONCAT_PACKER_LAST_EN, COUNT=4: beat 0001 with in_last → out_data = 0001_0000_0000_0000, out_count = 1; a full 4-beat word → out_count = 4.
